cmul_seq_hs: RTL

- Parametrised, handshaked successor of the team's 8-bit 3-multiplier complex multiplier.
- Computes P = X*Y, or X*conj(Y), for signed complex operands of DATA_W bits.
- Uses one shared registered multiplier over three passes (Gauss 3-mult form), with per-transaction mode and output saturation.
- Sits in the datapath between sample sources and the accumulate/FFT stages; supports full valid/ready backpressure on both sides.

---
 rtl/cmul_seq_hs.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cmul_seq_hs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cmul_seq_hs
//  Description : Handshaked sequential complex multiplier, P = X*Y or
//                X*conj(Y), using one shared registered multiplier over three
//                passes (Gauss 3-mult form) with optional output saturation.
//  Ports       : clk, rst          - clock, async active-high reset
//                in_valid/in_ready - input handshake (re_a, im_a, re_b,
//                                    im_b, conj_b sampled on transfer)
//                out_valid/out_ready - output handshake (re_out, im_out, sat)
//  Parameters  : DATA_W - signed operand component width (>= 2)
//                OUT_W  - signed result component width (<= 2*DATA_W+1);
//                         narrower than 2*DATA_W+1 enables clamping
//  Revision    : 1.0 - initial release
// ============================================================================
module cmul_seq_hs #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 2*DATA_W+1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] re_a,
    input  logic [DATA_W-1:0] im_a,
    input  logic [DATA_W-1:0] re_b,
    input  logic [DATA_W-1:0] im_b,
    input  logic              conj_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  re_out,
    output logic [OUT_W-1:0]  im_out,
    output logic              sat
);

    localparam int SW = DATA_W + 2;      // sum width
    localparam int PW = 2*DATA_W + 3;    // product / combination width

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_M1   = 3'd1;
    localparam logic [2:0] S_M2   = 3'd2;
    localparam logic [2:0] S_M3   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [2:0]               state_q, state_d;
    logic signed [DATA_W-1:0] a_q, b_q, c_q;
    logic signed [DATA_W:0]   d_q;
    logic signed [PW-1:0]     mreg_q, mreg_d;
    logic signed [PW-1:0]     k1_q, k2_q;
    logic [OUT_W-1:0]         re_q, im_q;
    logic                     sat_q;

    logic                     w_accept;
    logic [DATA_W:0]          w_d_new;
    logic signed [SW-1:0]     w_a_s, w_b_s, w_c_s, w_d_s;
    logic signed [SW-1:0]     w_sum_ab, w_dif_dc, w_sum_cd;
    logic signed [PW-1:0]     w_op1, w_op2;
    logic signed [PW-1:0]     w_re_full, w_im_full;
    logic [OUT_W-1:0]         w_re_clip, w_im_clip;
    logic                     w_sat_re, w_sat_im;

    // Clamp a full-precision component to OUT_W bits; MSB of result flags a clip.
    function automatic logic [OUT_W:0] clamp_f(input logic signed [PW-1:0] v);
        logic [OUT_W:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            r = {1'b0, v[OUT_W-1:0]};
        end
        return r;
    endfunction

    // in_ready depends only on state and out_ready, never on in_valid.
    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_OUT) & out_ready);
    assign out_valid = (state_q == S_OUT);
    assign w_accept  = in_valid & in_ready;
    assign re_out    = re_q;
    assign im_out    = im_q;
    assign sat       = sat_q;

    // One extra bit so that negating the most negative im_b stays exact.
    assign w_d_new = conj_b ? ({(DATA_W+1){1'b0}} - {im_b[DATA_W-1], im_b})
                            : {im_b[DATA_W-1], im_b};

    assign w_a_s    = {{2{a_q[DATA_W-1]}}, a_q};
    assign w_b_s    = {{2{b_q[DATA_W-1]}}, b_q};
    assign w_c_s    = {{2{c_q[DATA_W-1]}}, c_q};
    assign w_d_s    = {d_q[DATA_W], d_q};
    assign w_sum_ab = w_a_s + w_b_s;
    assign w_dif_dc = w_d_s - w_c_s;
    assign w_sum_cd = w_c_s + w_d_s;

    // Multiplier operand selection: k1 = c*(a+b), k2 = a*(d-c), k3 = b*(c+d).
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        case (state_q)
            S_M1: begin
                w_op1 = {{(PW-DATA_W){c_q[DATA_W-1]}}, c_q};
                w_op2 = {{(PW-SW){w_sum_ab[SW-1]}}, w_sum_ab};
            end
            S_M2: begin
                w_op1 = {{(PW-DATA_W){a_q[DATA_W-1]}}, a_q};
                w_op2 = {{(PW-SW){w_dif_dc[SW-1]}}, w_dif_dc};
            end
            S_M3: begin
                w_op1 = {{(PW-DATA_W){b_q[DATA_W-1]}}, b_q};
                w_op2 = {{(PW-SW){w_sum_cd[SW-1]}}, w_sum_cd};
            end
            default: begin
                w_op1 = '0;
                w_op2 = '0;
            end
        endcase
    end

    // The true product always fits PW bits, so the low PW bits are exact.
    assign mreg_d = w_op1 * w_op2;

    // In FIN, mreg holds k3 while k1 and k2 sit in their save registers.
    assign w_re_full = k1_q - mreg_q;
    assign w_im_full = k1_q + k2_q;
    assign {w_sat_re, w_re_clip} = clamp_f(w_re_full);
    assign {w_sat_im, w_im_clip} = clamp_f(w_im_full);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = in_valid ? S_M1 : S_IDLE;
            S_M1:    state_d = S_M2;
            S_M2:    state_d = S_M3;
            S_M3:    state_d = S_FIN;
            S_FIN:   state_d = S_OUT;
            S_OUT:   begin
                if (out_ready) begin
                    state_d = in_valid ? S_M1 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            mreg_q  <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            re_q    <= '0;
            im_q    <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mreg_q  <= mreg_d;
            if (w_accept) begin
                a_q <= re_a;
                b_q <= im_a;
                c_q <= re_b;
                d_q <= w_d_new;
            end
            if (state_q == S_M2) begin
                k1_q <= mreg_q;
            end
            if (state_q == S_M3) begin
                k2_q <= mreg_q;
            end
            if (state_q == S_FIN) begin
                re_q  <= w_re_clip;
                im_q  <= w_im_clip;
                sat_q <= w_sat_re | w_sat_im;
            end
        end
    end

endmodule
`default_nettype wire
